pong_match_ctrl: RTL and testbench

- Match sequencer for the Pong design. Owns the game state (idle, serve, play, point pause, game over) and both score counters.
- Gates ball and bar animation, requests ball re-centre/serve, and selects serve direction.
- Sits between the ball animator's score pulses, the START button and the vga640x480 frame strobe (animate).

---
 rtl/pong_pkg.sv | 23 ++
 rtl/btn_sync_edge.sv | 35 +++
 rtl/pong_match_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared state encodings, directions and widths for the Pong
//                match sequencer.
//  Revision    : 1.0
// ============================================================================
package pong_pkg;

    localparam int SCORE_W = 4;
    localparam int FRAME_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_sync_edge
//  Description : Two-flop synchroniser for an asynchronous button followed by
//                a single-pulse rising-edge detector.
//  Revision    : 1.0
// ============================================================================
module btn_sync_edge (
    input  logic in_clock,
    input  logic in_reset,
    input  logic in_button,
    output logic out_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= in_button;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Decoded from flops only, so the pulse is glitch-free for one cycle.
    assign out_rise = r_sync2 & ~r_prev;

endmodule : btn_sync_edge
`default_nettype wire

// File: rtl/pong_match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pong_match_ctrl
//  Description : Pong match sequencer: game state, scores, serve control and
//                animation gating.
//  Revision    : 1.0
// ============================================================================
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_POINTS   = 5,
    parameter int SERVE_FRAMES = 30,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic               in_clock,
    input  logic               in_reset,
    input  logic               in_animate,
    input  logic               in_start,
    input  logic               in_left_score,
    input  logic               in_right_score,
    output logic               out_ball_run,
    output logic               out_bars_run,
    output logic               out_ball_serve,
    output logic               out_serve_dir,
    output logic [SCORE_W-1:0] out_left_pts,
    output logic [SCORE_W-1:0] out_right_pts,
    output logic [2:0]         out_state,
    output logic               out_winner
);

    localparam logic [SCORE_W-1:0] c_win        = SCORE_W'(WIN_POINTS);
    localparam logic [FRAME_W-1:0] c_serve_last = FRAME_W'(SERVE_FRAMES - 1);
    localparam logic [FRAME_W-1:0] c_pause_last = FRAME_W'(PAUSE_FRAMES - 1);

    logic               w_start_edge;
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [FRAME_W-1:0] w_frame_cnt_nxt;
    logic [SCORE_W-1:0] r_left_pts;
    logic [SCORE_W-1:0] r_right_pts;
    logic [SCORE_W-1:0] w_left_pts_nxt;
    logic [SCORE_W-1:0] w_right_pts_nxt;
    logic [SCORE_W-1:0] w_left_inc;
    logic [SCORE_W-1:0] w_right_inc;
    logic               r_serve_dir;
    logic               w_serve_dir_nxt;
    logic               r_winner;
    logic               w_winner_nxt;
    logic               r_ball_run;
    logic               r_bars_run;
    logic               r_ball_serve;
    logic               w_ball_run_nxt;
    logic               w_bars_run_nxt;
    logic               w_ball_serve_nxt;

    btn_sync_edge u_start_sync (
        .in_clock  (in_clock),
        .in_reset  (in_reset),
        .in_button (in_start),
        .out_rise  (w_start_edge)
    );

    assign w_left_inc  = r_left_pts  + SCORE_W'(1);
    assign w_right_inc = r_right_pts + SCORE_W'(1);

    // State, scores, direction and winner registers
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            r_state      <= ST_IDLE;
            r_frame_cnt  <= '0;
            r_left_pts   <= '0;
            r_right_pts  <= '0;
            r_serve_dir  <= DIR_RIGHT;
            r_winner     <= 1'b0;
            r_ball_run   <= 1'b0;
            r_bars_run   <= 1'b0;
            r_ball_serve <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_left_pts   <= w_left_pts_nxt;
            r_right_pts  <= w_right_pts_nxt;
            r_serve_dir  <= w_serve_dir_nxt;
            r_winner     <= w_winner_nxt;
            r_ball_run   <= w_ball_run_nxt;
            r_bars_run   <= w_bars_run_nxt;
            r_ball_serve <= w_ball_serve_nxt;
        end
    end

    // Next-state and match bookkeeping
    always_comb begin
        w_state_nxt     = r_state;
        w_left_pts_nxt  = r_left_pts;
        w_right_pts_nxt = r_right_pts;
        w_serve_dir_nxt = r_serve_dir;
        w_winner_nxt    = r_winner;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) w_state_nxt = ST_SERVE;
            end
            ST_SERVE: begin
                if (in_animate && (r_frame_cnt == c_serve_last)) w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (in_left_score && in_right_score) begin
                    w_state_nxt = ST_POINT;
                end else if (in_left_score) begin
                    w_left_pts_nxt  = w_left_inc;
                    w_serve_dir_nxt = DIR_RIGHT;
                    if (w_left_inc == c_win) begin
                        w_state_nxt  = ST_OVER;
                        w_winner_nxt = DIR_LEFT;
                    end else begin
                        w_state_nxt = ST_POINT;
                    end
                end else if (in_right_score) begin
                    w_right_pts_nxt = w_right_inc;
                    w_serve_dir_nxt = DIR_LEFT;
                    if (w_right_inc == c_win) begin
                        w_state_nxt  = ST_OVER;
                        w_winner_nxt = DIR_RIGHT;
                    end else begin
                        w_state_nxt = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (in_animate && (r_frame_cnt == c_pause_last)) w_state_nxt = ST_SERVE;
            end
            ST_OVER: begin
                if (w_start_edge) begin
                    w_state_nxt     = ST_IDLE;
                    w_left_pts_nxt  = '0;
                    w_right_pts_nxt = '0;
                    w_winner_nxt    = 1'b0;
                    w_serve_dir_nxt = DIR_RIGHT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs decoded from the state being entered
    always_comb begin
        w_ball_run_nxt   = (w_state_nxt == ST_PLAY);
        w_bars_run_nxt   = (w_state_nxt == ST_SERVE) || (w_state_nxt == ST_PLAY);
        w_ball_serve_nxt = (w_state_nxt == ST_SERVE) && (r_state != ST_SERVE);
        w_frame_cnt_nxt  = r_frame_cnt;
        if (w_state_nxt != r_state) begin
            w_frame_cnt_nxt = '0;
        end else if (in_animate && ((r_state == ST_SERVE) || (r_state == ST_POINT))) begin
            w_frame_cnt_nxt = r_frame_cnt + FRAME_W'(1);
        end
    end

    assign out_state      = r_state;
    assign out_left_pts   = r_left_pts;
    assign out_right_pts  = r_right_pts;
    assign out_serve_dir  = r_serve_dir;
    assign out_winner     = r_winner;
    assign out_ball_run   = r_ball_run;
    assign out_bars_run   = r_bars_run;
    assign out_ball_serve = r_ball_serve;

endmodule : pong_match_ctrl
`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pong_match_ctrl
//  Description : Directed self-checking bench for pong_match_ctrl.
//  Revision    : 1.0
// ============================================================================
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       animate;
    logic       start;
    logic       lscore;
    logic       rscore;
    logic       ball_run;
    logic       bars_run;
    logic       ball_serve;
    logic       serve_dir;
    logic [3:0] left_pts;
    logic [3:0] right_pts;
    logic [2:0] state;
    logic       winner;

    int checks = 0;
    int errors = 0;

    pong_match_ctrl #(
        .WIN_POINTS   (3),
        .SERVE_FRAMES (2),
        .PAUSE_FRAMES (3)
    ) dut (
        .in_clock       (clk),
        .in_reset       (rst_n),
        .in_animate     (animate),
        .in_start       (start),
        .in_left_score  (lscore),
        .in_right_score (rscore),
        .out_ball_run   (ball_run),
        .out_bars_run   (bars_run),
        .out_ball_serve (ball_serve),
        .out_serve_dir  (serve_dir),
        .out_left_pts   (left_pts),
        .out_right_pts  (right_pts),
        .out_state      (state),
        .out_winner     (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic anim();
        animate = 1'b1;
        step(1);
        animate = 1'b0;
    endtask

    // From freshly entered POINT: 3 frames of pause, serve, 2 frames to PLAY.
    task automatic point_to_play(input string tag);
        anim();
        anim();
        chk({tag, "_pause2_state"}, state, 3);
        anim();
        chk({tag, "_pause3_state"}, state, 1);
        chk({tag, "_serve_pulse"}, ball_serve, 1);
        anim();
        chk({tag, "_serve_pulse_end"}, ball_serve, 0);
        anim();
        chk({tag, "_play_state"}, state, 2);
    endtask

    initial begin
        rst_n = 1'b0; animate = 1'b0; start = 1'b0; lscore = 1'b0; rscore = 1'b0;
        step(3);
        chk("rst_state", state, 0);
        chk("rst_pts", {left_pts, right_pts}, 0);
        chk("rst_dir", serve_dir, 1);
        chk("rst_runs", {ball_run, bars_run, ball_serve, winner}, 0);
        rst_n = 1'b1;
        step(2);
        chk("idle_hold", state, 0);

        // Start edge latency: raised before edge k, state changes at edge k+2
        start = 1'b1;
        step(2);
        chk("start_k1_state", state, 0);
        step(1);
        chk("start_k2_state", state, 1);
        chk("start_serve_pulse", ball_serve, 1);
        chk("serve_runs", {ball_run, bars_run}, 2'b01);
        step(1);
        chk("serve_pulse_one", ball_serve, 0);
        // Held button: no further transitions
        step(1000);
        chk("held_start_state", state, 1);
        start = 1'b0;
        anim();
        chk("serve_frame1_state", state, 1);
        anim();
        chk("serve_frame2_state", state, 2);
        chk("play_runs", {ball_run, bars_run}, 2'b11);

        // Left point
        lscore = 1'b1; step(1); lscore = 1'b0;
        chk("lpt_left", left_pts, 1);
        chk("lpt_state", state, 3);
        chk("lpt_dir", serve_dir, 1);
        chk("lpt_runs", {ball_run, bars_run}, 0);
        rscore = 1'b1; step(1); rscore = 1'b0;
        chk("point_filter_right", right_pts, 0);
        anim(); anim();
        chk("lpt_pause2", state, 3);
        anim();
        chk("lpt_pause3", state, 1);
        chk("lpt_serve_pulse", ball_serve, 1);
        lscore = 1'b1; step(1); lscore = 1'b0;
        chk("serve_filter_left", left_pts, 1);
        anim(); anim();
        chk("lpt_back_play", state, 2);

        // Right point 1
        rscore = 1'b1; step(1); rscore = 1'b0;
        chk("r1_pts", {left_pts, right_pts}, 8'h11);
        chk("r1_state", state, 3);
        chk("r1_dir", serve_dir, 0);
        point_to_play("r1");

        // Simultaneous: replay, nothing changes
        lscore = 1'b1; rscore = 1'b1; step(1); lscore = 1'b0; rscore = 1'b0;
        chk("both_pts", {left_pts, right_pts}, 8'h11);
        chk("both_state", state, 3);
        chk("both_dir", serve_dir, 0);
        point_to_play("both");

        // Right point 2, then winning point 3
        rscore = 1'b1; step(1); rscore = 1'b0;
        chk("r2_pts", right_pts, 2);
        chk("r2_state", state, 3);
        point_to_play("r2");
        rscore = 1'b1; step(1); rscore = 1'b0;
        chk("win_right_pts", right_pts, 3);
        chk("win_state", state, 4);
        chk("win_winner", winner, 1);
        chk("win_runs", {ball_run, bars_run}, 0);
        lscore = 1'b1; step(1); lscore = 1'b0;
        rscore = 1'b1; step(1); rscore = 1'b0;
        anim();
        chk("over_filter_pts", {left_pts, right_pts}, 8'h13);
        chk("over_hold", state, 4);

        // Start edge from OVER clears the match
        start = 1'b1;
        step(3);
        start = 1'b0;
        chk("over_start_state", state, 0);
        chk("over_start_pts", {left_pts, right_pts}, 0);
        chk("over_start_winner", winner, 0);
        chk("over_start_dir", serve_dir, 1);
        step(3);
        chk("idle_after_over", state, 0);

        // New match, reach POINT with the frame counter at 2, then async reset
        start = 1'b1; step(3); start = 1'b0;
        chk("m2_serve", state, 1);
        anim(); anim();
        chk("m2_play", state, 2);
        rscore = 1'b1; step(1); rscore = 1'b0;
        chk("m2_point_dir", serve_dir, 0);
        anim(); anim();
        chk("m2_point_cnt2", state, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", state, 0);
        chk("async_pts", {left_pts, right_pts}, 0);
        chk("async_dir", serve_dir, 1);
        chk("async_runs", {ball_run, bars_run, ball_serve, winner}, 0);
        step(1);
        rst_n = 1'b1;
        step(5);
        chk("post_rst_idle", state, 0);
        start = 1'b1; step(3); start = 1'b0;
        chk("post_rst_serve", state, 1);
        chk("post_rst_pulse", ball_serve, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mid_pulse", {state, ball_serve, bars_run}, 0);
        step(1);
        rst_n = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pong_match_ctrl
`default_nettype wire
